// File: rtl/uart_line_buffer.sv
// uart_line_buffer: captures characters popped from the uart_rx FIFO into a
// DEPTH-entry line RAM, optionally echoing each one, and replays the stored
// line to the uart_tx FIFO on a start pulse or on a captured terminator.
// All outputs are registered; strobes are high for exactly one cycle.
module uart_line_buffer #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 64,
  parameter int                    ADDR_WIDTH = 6,
  parameter logic [DATA_WIDTH-1:0] TERMINATOR = 8'h0D,
  parameter bit                    AUTO_SEND  = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  echo_en,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_data_present,
  input  logic                  tx_full,
  output logic                  read_from_uart,
  output logic                  write_to_uart,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  send_done
);

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_CAP_GAP = 2'd1,
    ST_SEND_RD = 2'd2,
    ST_SEND_WR = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1'b1);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO  = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1'b1);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  state_t                  state_r;
  logic [ADDR_WIDTH-1:0]   wr_ptr_r;
  logic [ADDR_WIDTH-1:0]   rd_ptr_r;
  logic [ADDR_WIDTH:0]     count_r;
  logic                    ovf_r;
  logic                    start_pend_r;
  logic                    term_hit_r;
  logic                    last_push_r;
  logic                    read_r;
  logic                    write_r;
  logic                    busy_r;
  logic                    done_r;
  logic [DATA_WIDTH-1:0]   tx_data_r;
  logic [DATA_WIDTH-1:0]   ram_q_r;
  logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

  logic                    start_ok_s;
  logic                    send_now_s;
  logic                    pop_s;
  logic                    store_s;
  logic                    last_s;

  // Decode this cycle's capture/send decisions from state and handshakes
  always_comb begin
    start_ok_s = 1'b0;
    send_now_s = 1'b0;
    pop_s      = 1'b0;
    store_s    = 1'b0;
    last_s     = 1'b0;
    // a start with an empty buffer is dropped, never latched
    start_ok_s = start && (count_r != CNT_ZERO);
    if (state_r == ST_CAPTURE) begin
      // a pending or fresh start wins over a pop in the same cycle
      send_now_s = start_pend_r || start_ok_s;
      pop_s      = !send_now_s && rx_data_present && (!echo_en || !tx_full);
    end else begin
      send_now_s = 1'b0;
      pop_s      = 1'b0;
    end
    store_s = pop_s && (count_r != CNT_FULL);
    last_s  = (({1'b0, rd_ptr_r}) + CNT_ONE) == count_r;
  end

  // Line RAM: capture-side write and registered replay-side read
  always_ff @(posedge clock) begin
    if (store_s) begin
      mem_r[wr_ptr_r] <= rx_data;
    end
    if (state_r == ST_SEND_RD) begin
      ram_q_r <= mem_r[rd_ptr_r];
    end
  end

  // Control FSM with registered strobes, pointers and status
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_CAPTURE;
      wr_ptr_r     <= PTR_ZERO;
      rd_ptr_r     <= PTR_ZERO;
      count_r      <= CNT_ZERO;
      ovf_r        <= 1'b0;
      start_pend_r <= 1'b0;
      term_hit_r   <= 1'b0;
      last_push_r  <= 1'b0;
      read_r       <= 1'b0;
      write_r      <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      tx_data_r    <= DATA_ZERO;
    end else begin
      read_r      <= 1'b0;
      write_r     <= 1'b0;
      last_push_r <= 1'b0;
      // send_done trails the final push strobe by one cycle
      done_r      <= last_push_r;
      case (state_r)
        ST_CAPTURE: begin
          if (send_now_s) begin
            state_r      <= ST_SEND_RD;
            busy_r       <= 1'b1;
            start_pend_r <= 1'b0;
          end else if (pop_s) begin
            read_r     <= 1'b1;
            state_r    <= ST_CAP_GAP;
            term_hit_r <= AUTO_SEND && store_s && (rx_data == TERMINATOR);
            if (store_s) begin
              wr_ptr_r <= wr_ptr_r + PTR_ONE;
              count_r  <= count_r + CNT_ONE;
              if (echo_en) begin
                write_r   <= 1'b1;
                tx_data_r <= rx_data;
              end else begin
                write_r   <= 1'b0;
              end
            end else begin
              // buffer full: the character is dropped and flagged
              ovf_r <= 1'b1;
            end
          end else begin
            state_r <= ST_CAPTURE;
          end
        end
        ST_CAP_GAP: begin
          term_hit_r <= 1'b0;
          if (term_hit_r) begin
            state_r      <= ST_SEND_RD;
            busy_r       <= 1'b1;
            start_pend_r <= 1'b0;
          end else begin
            // a start here takes effect in the following capture cycle
            state_r      <= ST_CAPTURE;
            start_pend_r <= start_ok_s;
          end
        end
        ST_SEND_RD: begin
          state_r <= ST_SEND_WR;
        end
        ST_SEND_WR: begin
          if (!tx_full) begin
            write_r   <= 1'b1;
            tx_data_r <= ram_q_r;
            if (last_s) begin
              state_r     <= ST_CAPTURE;
              busy_r      <= 1'b0;
              count_r     <= CNT_ZERO;
              wr_ptr_r    <= PTR_ZERO;
              rd_ptr_r    <= PTR_ZERO;
              ovf_r       <= 1'b0;
              last_push_r <= 1'b1;
            end else begin
              rd_ptr_r <= rd_ptr_r + PTR_ONE;
              state_r  <= ST_SEND_RD;
            end
          end else begin
            state_r <= ST_SEND_WR;
          end
        end
        default: begin
          state_r <= ST_CAPTURE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign read_from_uart = read_r;
  assign write_to_uart  = write_r;
  assign tx_data        = tx_data_r;
  assign busy           = busy_r;
  assign count          = count_r;
  assign overflow       = ovf_r;
  assign send_done      = done_r;

endmodule

// File: tb/tb_uart_line_buffer.sv
// Bench for uart_line_buffer: models the rx/tx FIFOs around the DUT, keeps a
// transaction-level reference of the line buffer, and checks every cycle.
module tb_uart_line_buffer;
  localparam int DEPTH  = 4;
  localparam int TX_CAP = 4;
  localparam logic [7:0] TERM = 8'h0D;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       echo_en = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_data_present = 1'b0;
  logic       tx_full = 1'b0;
  logic       read_from_uart, write_to_uart, busy, overflow, send_done;
  logic [7:0] tx_data;
  logic [2:0] count;

  uart_line_buffer #(.DATA_WIDTH(8), .DEPTH(DEPTH), .ADDR_WIDTH(2),
                     .TERMINATOR(TERM), .AUTO_SEND(1'b1)) dut (
    .clock(clock), .reset(reset), .start(start), .echo_en(echo_en),
    .rx_data(rx_data), .rx_data_present(rx_data_present), .tx_full(tx_full),
    .read_from_uart(read_from_uart), .write_to_uart(write_to_uart),
    .tx_data(tx_data), .busy(busy), .count(count), .overflow(overflow),
    .send_done(send_done));

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // ---------------- environment: rx FIFO, tx FIFO, input samples ----------
  logic [7:0] rxq[$];
  logic [7:0] tx_log[$];
  int         pop_cyc[$];
  int         cyc = 0, tx_lvl = 0, done_cnt = 0, lvl_set_val = 0;
  logic       inj_v = 1'b0, drain_en = 1'b1, lvl_set_v = 1'b0;
  logic [7:0] inj_b = 8'h00;
  logic       s_start = 1'b0, s_echo = 1'b0, s_inj_v = 1'b0;
  logic [7:0] s_inj_b = 8'h00;

  always @(posedge clock) begin
    int lvl;
    s_start <= start;
    s_echo  <= echo_en;
    s_inj_v <= inj_v;
    s_inj_b <= inj_b;
    if (read_from_uart && rxq.size() != 0) begin
      void'(rxq.pop_front());
      pop_cyc.push_back(cyc);
    end
    if (inj_v) rxq.push_back(inj_b);
    rx_data_present <= (rxq.size() != 0);
    rx_data <= (rxq.size() != 0) ? rxq[0] : 8'h00;
    if (write_to_uart) tx_log.push_back(tx_data);
    lvl = tx_lvl;
    if (write_to_uart) lvl++;
    if (drain_en && lvl > 0 && $urandom_range(0, 1) == 1) lvl--;
    if (lvl_set_v) lvl = lvl_set_val;
    tx_lvl  <= lvl;
    tx_full <= (lvl >= TX_CAP);
    if (send_done) done_cnt <= done_cnt + 1;
    cyc <= cyc + 1;
  end

  // ---------------- reference model + per-cycle compare -------------------
  logic [7:0] exp_rx[$];
  logic [7:0] m_buf[$];
  logic [7:0] m_send[$];
  int         m_count = 0;
  bit         m_ovf = 1'b0, m_in_send = 1'b0, done_due = 1'b0, done_prev = 1'b0;

  initial begin : compare
    logic [7:0] c, e;
    bit echo_x;
    forever begin
      @(posedge clock); #1;
      if (s_inj_v) exp_rx.push_back(s_inj_b);
      if (reset == 1'b0) begin
        m_buf.delete(); m_send.delete();
        m_count = 0; m_ovf = 1'b0; m_in_send = 1'b0; done_prev = 1'b0;
      end else begin
        done_due = 1'b0;
        echo_x = 1'b0;
        if (s_start && !m_in_send && m_count > 0) begin
          m_in_send = 1'b1;
          foreach (m_buf[i]) m_send.push_back(m_buf[i]);
        end
        if (read_from_uart) begin
          chk(rx_data_present == 1'b1, "pop_needs_data", rx_data_present, 1);
          chk(busy == 1'b0, "pop_while_busy", busy, 0);
          if (exp_rx.size() == 0) begin
            chk(1'b0, "pop_empty_fifo", 1, 0);
            c = 8'h00;
          end else begin
            c = exp_rx.pop_front();
          end
          if (m_count < DEPTH) begin
            m_buf.push_back(c);
            m_count++;
            echo_x = s_echo;
            if (c == TERM) begin
              m_in_send = 1'b1;
              foreach (m_buf[i]) m_send.push_back(m_buf[i]);
            end
          end else begin
            m_ovf = 1'b1;
          end
          chk(write_to_uart == echo_x, "echo_strobe", write_to_uart, echo_x);
          if (echo_x) chk(tx_data == c, "echo_data", tx_data, c);
        end else if (write_to_uart) begin
          if (m_send.size() == 0) begin
            chk(1'b0, "unexpected_write", tx_data, -1);
          end else begin
            e = m_send.pop_front();
            chk(tx_data == e, "send_data", tx_data, e);
            if (m_send.size() == 0) begin
              m_in_send = 1'b0; m_count = 0; m_ovf = 1'b0;
              m_buf.delete(); done_due = 1'b1;
            end
          end
        end
        if (write_to_uart) chk(tx_full == 1'b0, "write_while_full", tx_full, 0);
        if (busy) chk(m_in_send, "busy_without_send", busy, m_in_send);
        chk(send_done == done_prev, "send_done", send_done, done_prev);
        done_prev = done_due;
        chk(int'(count) == m_count, "count", count, m_count);
        chk(overflow == m_ovf, "overflow", overflow, m_ovf);
      end
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic put_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clock); inj_v = 1'b1; inj_b = s[i];
    end
    @(negedge clock); inj_v = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  task automatic set_lvl(input int v);
    @(negedge clock); lvl_set_v = 1'b1; lvl_set_val = v;
    @(negedge clock); lvl_set_v = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int quiet = 0;
    for (int i = 0; i < budget && quiet < 4; i++) begin
      @(negedge clock);
      if (!rx_data_present && !busy && !read_from_uart && !write_to_uart) quiet++;
      else quiet = 0;
    end
    chk(quiet >= 4, "idle_timeout", quiet, 4);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(read_from_uart == 1'b0, {tag, "_read"}, read_from_uart, 0);
    chk(write_to_uart == 1'b0, {tag, "_write"}, write_to_uart, 0);
    chk(tx_data == 8'h00, {tag, "_tx_data"}, tx_data, 0);
    chk(busy == 1'b0, {tag, "_busy"}, busy, 0);
    chk(count == 3'd0, {tag, "_count"}, count, 0);
    chk(overflow == 1'b0, {tag, "_overflow"}, overflow, 0);
    chk(send_done == 1'b0, {tag, "_send_done"}, send_done, 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------------------
  initial begin : stim
    int b0, d0, seen, nfull, nwr, r;
    repeat (3) @(negedge clock);
    #1 chk_all_zero("reset");
    @(negedge clock); reset = 1'b1;

    // echo "AB": two pops two cycles apart, echoed in order, count 2
    echo_en = 1'b1;
    b0 = tx_log.size(); d0 = pop_cyc.size();
    put_str("AB");
    wait_idle(200);
    chk(tx_log.size() - b0 == 2, "t1_echo_len", tx_log.size() - b0, 2);
    chk(tx_log[b0] == 8'h41, "t1_echo0", tx_log[b0], 8'h41);
    chk(tx_log[b0+1] == 8'h42, "t1_echo1", tx_log[b0+1], 8'h42);
    chk(count == 3'd2, "t1_count", count, 2);
    chk(pop_cyc[d0+1] - pop_cyc[d0] == 2, "t1_pop_gap", pop_cyc[d0+1] - pop_cyc[d0], 2);
    b0 = tx_log.size();
    pulse_start();
    wait_idle(200);
    chk(tx_log[b0] == 8'h41 && tx_log[b0+1] == 8'h42, "t1_replay", tx_log[b0+1], 8'h42);

    // "HI\r" without echo: terminator triggers auto-send
    echo_en = 1'b0;
    b0 = tx_log.size(); d0 = done_cnt;
    put_str("HI\r");
    wait_idle(200);
    chk(tx_log.size() - b0 == 3, "t2_len", tx_log.size() - b0, 3);
    chk(tx_log[b0] == 8'h48, "t2_c0", tx_log[b0], 8'h48);
    chk(tx_log[b0+1] == 8'h49, "t2_c1", tx_log[b0+1], 8'h49);
    chk(tx_log[b0+2] == 8'h0D, "t2_c2", tx_log[b0+2], 8'h0D);
    chk(done_cnt - d0 == 1, "t2_done", done_cnt - d0, 1);
    chk(count == 3'd0, "t2_count", count, 0);

    // start with empty buffer is ignored
    b0 = tx_log.size(); seen = 0;
    pulse_start();
    repeat (8) begin @(negedge clock); if (busy || write_to_uart) seen++; end
    chk(seen == 0, "t4_empty_start", seen, 0);

    // overflow with DEPTH=4, then replay of the first four
    put_str("012345");
    wait_idle(200);
    chk(overflow == 1'b1, "t3_ovf_set", overflow, 1);
    chk(count == 3'd4, "t3_count", count, 4);
    b0 = tx_log.size();
    pulse_start();
    wait_idle(200);
    chk(tx_log.size() - b0 == 4, "t3_len", tx_log.size() - b0, 4);
    chk(tx_log[b0+3] == 8'h33, "t3_last", tx_log[b0+3], 8'h33);
    chk(overflow == 1'b0, "t3_ovf_clr", overflow, 0);

    // second start during a send is ignored
    put_str("xyz");
    wait_idle(200);
    b0 = tx_log.size(); d0 = done_cnt;
    pulse_start();
    chk(busy == 1'b1, "t4_busy", busy, 1);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    wait_idle(200);
    chk(tx_log.size() - b0 == 3, "t4_one_replay", tx_log.size() - b0, 3);
    chk(done_cnt - d0 == 1, "t4_one_done", done_cnt - d0, 1);

    // tx stall mid-send: no strobes while full, order intact after release
    put_str("wxyv");
    wait_idle(200);
    drain_en = 1'b0;
    set_lvl(2);
    b0 = tx_log.size();
    pulse_start();
    for (int i = 0; i < 40 && !tx_full; i++) @(negedge clock);
    nfull = 0; nwr = 0;
    repeat (20) begin @(negedge clock); if (tx_full) nfull++; if (write_to_uart) nwr++; end
    chk(nfull == 20, "t5_full_held", nfull, 20);
    chk(nwr == 0, "t5_no_write", nwr, 0);
    drain_en = 1'b1;
    wait_idle(300);
    chk(tx_log.size() - b0 == 4, "t5_len", tx_log.size() - b0, 4);
    chk(tx_log[b0] == 8'h77 && tx_log[b0+3] == 8'h76, "t5_order", tx_log[b0+3], 8'h76);

    // randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      inj_v = 1'b0; start = 1'b0;
      r = $urandom_range(0, 15);
      if (r < 6) begin
        inj_v = 1'b1;
        inj_b = (r == 0) ? TERM : 8'($urandom_range(32, 126));
      end
      if (r == 7) start = 1'b1;
      if (r == 8) echo_en = ~echo_en;
      if (r == 9) drain_en = ($urandom_range(0, 3) != 0);
    end
    @(negedge clock); inj_v = 1'b0; start = 1'b0; drain_en = 1'b1;
    wait_idle(3000);
    pulse_start();
    wait_idle(300);

    // reset while stalled in SEND_WR aborts at once
    echo_en = 1'b0;
    put_str("pq");
    wait_idle(200);
    drain_en = 1'b0;
    set_lvl(TX_CAP);
    pulse_start();
    repeat (5) @(negedge clock);
    chk(busy == 1'b1, "t6_busy_before", busy, 1);
    reset = 1'b0;
    #1 chk_all_zero("t6_reset");
    repeat (2) @(negedge clock);
    reset = 1'b1; drain_en = 1'b1;
    @(negedge clock);
    chk(count == 3'd0, "t6_count_after", count, 0);
    put_str("k");
    wait_idle(200);
    chk(count == 3'd1, "t6_capture_resumes", count, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
